// File: rtl/fft_pkg.sv
// fft_pkg: types and helpers shared by the SDF FFT stage controllers.
//   sdf_state_t : controller state encoding
//   clog2()     : ceiling log2, usable in constant expressions
package fft_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } sdf_state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: sequencer for one radix-2 single-delay-feedback FFT stage.
// Tracks the sample index k of the frame and produces the registered
// butterfly select, twiddle enable/address and output framing for the
// datapath, which has a one-cycle input register (outputs describe the
// sample accepted on the previous edge).
//
// Ports:
//   clk        in   clock, rising edge
//   clr        in   asynchronous active-high reset
//   in_valid   in   input sample present
//   in_sync    in   sample is frame index 0 (qualified by in_valid)
//   bf_sel     out  0 = pass sample into delay line, 1 = butterfly
//   tw_en      out  apply twiddle to delay-line output
//   tw_addr    out  twiddle ROM address
//   out_valid  out  stage output sample valid
//   out_sync   out  first output sample of a frame
//   busy       out  controller not idle
//   err        out  sticky protocol error
//
// Build option: SDF_CTRL_ERR_EN -- when defined, protocol violations set the
// sticky err flag and return the controller to idle. When undefined, err is
// 0, gaps in in_valid stall the frame and stray syncs/valids are ignored.
//
// state   | meaning
// S_IDLE  | waiting for in_valid & in_sync (frame index 0)
// S_FILL  | first DELAY samples of a frame entering an empty delay line
// S_RUN   | remaining samples; a sync right after sample N-1 starts the next frame
// S_FLUSH | input done, last DELAY results draining from the delay line
module sdf_stage_ctrl
    import fft_pkg::*;
#(
    parameter int N_POINTS = 16,
    parameter int STAGE    = 0
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic                         in_sync,
    output logic                         bf_sel,
    output logic                         tw_en,
    output logic [clog2(N_POINTS)-1:0]   tw_addr,
    output logic                         out_valid,
    output logic                         out_sync,
    output logic                         busy,
    output logic                         err
);

    localparam int LOG2N  = clog2(N_POINTS);
    localparam int DELAY  = N_POINTS >> (STAGE + 1);
    localparam int KW     = LOG2N + 1;
    localparam int BF_BIT = LOG2N - 1 - STAGE;

    localparam logic [KW-1:0] K_ONE       = KW'(1);
    localparam logic [KW-1:0] K_DELAY     = KW'(DELAY);
    localparam logic [KW-1:0] K_FILL_END  = KW'(DELAY - 1);
    localparam logic [KW-1:0] K_RUN_END   = KW'(N_POINTS - 1);
    localparam logic [KW-1:0] K_FLUSH_0   = KW'(N_POINTS);
    localparam logic [KW-1:0] K_FLUSH_END = KW'(N_POINTS + DELAY - 1);
    localparam logic [KW-1:0] K_MOD_MASK  = KW'(DELAY - 1);

    // r_k holds the index of the next sample (or flush step) to process
    sdf_state_t         r_state;
    logic [KW-1:0]      r_k;
    logic               r_bf_sel;
    logic               r_tw_en;
    logic [LOG2N-1:0]   r_tw_addr;
    logic               r_out_valid;
    logic               r_out_sync;
    logic               r_busy;

    sdf_state_t         w_state_nxt;
    logic [KW-1:0]      w_k_nxt;
    logic               w_sof;
    logic               w_step;
    logic [KW-1:0]      w_step_k;
    logic               w_step_flush;
    logic               w_step_tail;
    logic               w_stall;
    logic               w_err;
    logic [KW-1:0]      w_k_mod;
    logic               w_bf_sel_nxt;
    logic               w_tw_en_nxt;
    logic [LOG2N-1:0]   w_tw_addr_nxt;
    logic               w_out_valid_nxt;
    logic               w_out_sync_nxt;
    logic               w_busy_nxt;

    assign w_sof = in_valid & in_sync;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_bf_sel    <= 1'b0;
            r_tw_en     <= 1'b0;
            r_tw_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_sync  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_bf_sel    <= w_bf_sel_nxt;
            r_tw_en     <= w_tw_en_nxt;
            r_tw_addr   <= w_tw_addr_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_sync  <= w_out_sync_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // A "step" is one sample index being processed this cycle; w_step_tail
    // marks the fill phase of a back-to-back frame, where the delay line
    // still holds the previous frame's last DELAY results.
    always_comb begin
        w_state_nxt  = r_state;
        w_k_nxt      = r_k;
        w_step       = 1'b0;
        w_step_k     = r_k;
        w_step_flush = 1'b0;
        w_step_tail  = 1'b0;
        w_stall      = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sof) begin
                    w_step      = 1'b1;
                    w_step_k    = '0;
                    w_k_nxt     = K_ONE;
                    w_state_nxt = (DELAY == 1) ? S_RUN : S_FILL;
                end
            end
            S_FILL, S_RUN: begin
                if (!in_valid) begin
                    w_stall = 1'b1;
                end else begin
                    w_step      = 1'b1;
                    w_k_nxt     = r_k + K_ONE;
                    w_step_tail = (r_state == S_RUN) && (r_k < K_DELAY);
                    if (r_state == S_FILL && r_k == K_FILL_END)
                        w_state_nxt = S_RUN;
                    if (r_state == S_RUN && r_k == K_RUN_END)
                        w_state_nxt = S_FLUSH;
                end
`ifdef SDF_CTRL_ERR_EN
                // r_k is never 0 here, so any sync is a mid-frame sync
                if (!in_valid || in_sync)
                    w_err = 1'b1;
`endif
            end
            S_FLUSH: begin
                if (r_k == K_FLUSH_0 && w_sof) begin
                    w_step      = 1'b1;
                    w_step_k    = '0;
                    w_step_tail = 1'b1;
                    w_k_nxt     = K_ONE;
                    w_state_nxt = S_RUN;
                end else begin
                    w_step       = 1'b1;
                    w_step_flush = 1'b1;
                    w_k_nxt      = r_k + K_ONE;
                    if (r_k == K_FLUSH_END)
                        w_state_nxt = S_IDLE;
`ifdef SDF_CTRL_ERR_EN
                    if (in_valid && r_k != K_FLUSH_0)
                        w_err = 1'b1;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_err) begin
            w_state_nxt = S_IDLE;
            w_step      = 1'b0;
            w_stall     = 1'b0;
        end
    end

    always_comb begin
        w_k_mod         = w_step_k & K_MOD_MASK;
        w_bf_sel_nxt    = 1'b0;
        w_tw_en_nxt     = 1'b0;
        w_tw_addr_nxt   = '0;
        w_out_valid_nxt = 1'b0;
        w_out_sync_nxt  = 1'b0;
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        if (w_step) begin
            w_bf_sel_nxt    = w_step_k[BF_BIT] & ~w_step_flush;
            w_tw_en_nxt     = ~w_bf_sel_nxt & ((w_step_k >= K_DELAY) | w_step_tail);
            w_tw_addr_nxt   = w_tw_en_nxt ? LOG2N'(w_k_mod << STAGE) : '0;
            w_out_valid_nxt = (w_step_k >= K_DELAY) | w_step_tail;
            w_out_sync_nxt  = (w_step_k == K_DELAY);
        end else if (w_stall) begin
            // a gap in the input freezes the datapath controls
            w_bf_sel_nxt  = r_bf_sel;
            w_tw_en_nxt   = r_tw_en;
            w_tw_addr_nxt = r_tw_addr;
        end
    end

`ifdef SDF_CTRL_ERR_EN
    logic r_err;
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_err <= 1'b0;
        else if (w_err)
            r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign bf_sel    = r_bf_sel;
    assign tw_en     = r_tw_en;
    assign tw_addr   = r_tw_addr;
    assign out_valid = r_out_valid;
    assign out_sync  = r_out_sync;
    assign busy      = r_busy;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb_sdf_stage_ctrl: testbench for sdf_stage_ctrl with N_POINTS=16, STAGE=1.
// Honours SDF_CTRL_ERR_EN in the same way as the design.
module tb_sdf_stage_ctrl;

    localparam int N  = 16;
    localparam int S  = 1;
    localparam int D  = N >> (S + 1);
    localparam int LW = 4;

    localparam int KIND_IDLE   = 0;
    localparam int KIND_SAMPLE = 1;
    localparam int KIND_STALL  = 2;
    localparam int KIND_FLUSH  = 3;
    localparam int KIND_ERR    = 4;

`ifdef SDF_CTRL_ERR_EN
    localparam bit ERR_BUILD = 1'b1;
`else
    localparam bit ERR_BUILD = 1'b0;
`endif

    typedef struct {
        int kind;
        int k;
        bit b2b;
        bit v;
        bit s;
    } cyc_t;

    logic          clk;
    logic          clr;
    logic          in_valid;
    logic          in_sync;
    logic          bf_sel;
    logic          tw_en;
    logic [LW-1:0] tw_addr;
    logic          out_valid;
    logic          out_sync;
    logic          busy;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    logic          e_bf, e_tw, e_ov, e_os, e_busy, e_err;
    logic [LW-1:0] e_addr;
    cyc_t          plan[$];

    sdf_stage_ctrl #(.N_POINTS(N), .STAGE(S)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_sync   (in_sync),
        .bf_sel    (bf_sel),
        .tw_en     (tw_en),
        .tw_addr   (tw_addr),
        .out_valid (out_valid),
        .out_sync  (out_sync),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LW+5:0] obs();
        return {bf_sel, tw_en, tw_addr, out_valid, out_sync, busy, err};
    endfunction

    function automatic logic [LW+5:0] expv();
        return {e_bf, e_tw, e_addr, e_ov, e_os, e_busy, e_err};
    endfunction

    function automatic cyc_t mk(input int kind, input int k, input bit b2b, input bit v, input bit s);
        cyc_t c;
        c.kind = kind; c.k = k; c.b2b = b2b; c.v = v; c.s = s;
        return c;
    endfunction

    // Frames of N samples (optionally back-to-back), random input gaps and
    // stray valid/sync noise, followed by the DELAY-cycle drain.
    task automatic add_group(input int nfr, input int stall_pct, input bit noise);
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < N; k++) begin
                if (k > 0)
                    for (int j = 0; j < 4 && $urandom_range(99) < stall_pct; j++)
                        plan.push_back(mk(KIND_STALL, k, f > 0, 1'b0, noise && $urandom_range(1) == 1));
                plan.push_back(mk(KIND_SAMPLE, k, f > 0, 1'b1,
                                  (k == 0) || (noise && $urandom_range(9) == 0)));
            end
        end
        for (int k = N; k < N + D; k++)
            plan.push_back(mk(KIND_FLUSH, k, 1'b0, noise && $urandom_range(1) == 1, 1'b0));
    endtask

    task automatic add_idle(input int n, input bit noise);
        for (int j = 0; j < n; j++)
            plan.push_back(mk(KIND_IDLE, 0, 1'b0, noise && $urandom_range(1) == 1, 1'b0));
    endtask

    // Drives one cycle and forms the expected outputs for the sample or
    // drain step taken in it: blocks of DELAY pass-through samples alternate
    // with DELAY butterfly samples, and every delay-line output from index
    // DELAY onwards (including a previous frame's tail) is twiddled.
    task automatic step(input cyc_t c);
        bit tail;
        in_valid = c.v;
        in_sync  = c.s;
        case (c.kind)
            KIND_SAMPLE: begin
                tail   = c.b2b && (c.k < D);
                e_bf   = (((c.k / D) % 2) == 1);
                e_tw   = !e_bf && (c.k >= D || tail);
                e_addr = e_tw ? LW'((c.k % D) << S) : '0;
                e_ov   = (c.k >= D) || tail;
                e_os   = (c.k == D);
                e_busy = 1'b1;
            end
            KIND_STALL: begin
                e_ov   = 1'b0;
                e_os   = 1'b0;
                e_busy = 1'b1;
            end
            KIND_FLUSH: begin
                e_bf   = 1'b0;
                e_tw   = 1'b1;
                e_addr = LW'((c.k % D) << S);
                e_ov   = 1'b1;
                e_os   = 1'b0;
                e_busy = (c.k < N + D - 1);
            end
            KIND_ERR: begin
                e_bf = 1'b0; e_tw = 1'b0; e_addr = '0;
                e_ov = 1'b0; e_os = 1'b0; e_busy = 1'b0; e_err = 1'b1;
            end
            default: begin
                e_bf = 1'b0; e_tw = 1'b0; e_addr = '0;
                e_ov = 1'b0; e_os = 1'b0; e_busy = 1'b0;
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        e_bf = 0; e_tw = 0; e_addr = '0; e_ov = 0; e_os = 0; e_busy = 0; e_err = 0;
        n_tests++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL reset_hold got %b want %b", obs(), expv());
        end
        clr = 1'b0;
        plan.delete();
        for (int k = 0; k < 9; k++) plan.push_back(mk(KIND_SAMPLE, k, 1'b0, 1'b1, k == 0));
        foreach (plan[i]) begin
            step(plan[i]);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL reset_pre[%0d] k=%0d got %b want %b", i, plan[i].k, obs(), expv());
            end
        end
        in_valid = 1'b1;
        in_sync  = 1'b0;
        #3;
        clr = 1'b1;
        #1;
        n_tests++;
        if (obs() !== '0) begin
            n_fail++;
            $display("FAIL reset_async got %b want %b", obs(), {(LW+6){1'b0}});
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        plan.delete();
        add_idle(8, 1'b1);
        foreach (plan[i]) begin
            step(plan[i]);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL reset_post[%0d] got %b want %b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_single_frame();
        logic [N-1:0] bf_pat;
        int ov_cnt, lat;
        time t_sync;
        bf_pat = '0; ov_cnt = 0; lat = -1; t_sync = 0;
        plan.delete();
        add_group(1, 0, 1'b0);
        add_idle(3, 1'b0);
        foreach (plan[i]) begin
            if (plan[i].s) t_sync = $time;
            step(plan[i]);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL single[%0d] k=%0d got %b want %b", i, plan[i].k, obs(), expv());
            end
            if (plan[i].kind == KIND_SAMPLE) bf_pat = {bf_pat[N-2:0], bf_sel};
            if (out_valid) ov_cnt++;
            if (out_sync && lat < 0) lat = int'(($time - t_sync) / 10);
        end
        n_tests++;
        if (bf_pat !== 16'b0000111100001111) begin
            n_fail++;
            $display("FAIL single_bf_pattern got %b want %b", bf_pat, 16'b0000111100001111);
        end
        n_tests++;
        if (ov_cnt != N) begin
            n_fail++;
            $display("FAIL single_ov_count got %0d want %0d", ov_cnt, N);
        end
        n_tests++;
        if (lat != D + 1) begin
            n_fail++;
            $display("FAIL single_sync_latency got %0d want %0d", lat, D + 1);
        end
    endtask

    task automatic test_twiddle();
        logic [15:0] addrs;
        int tw_lo;
        addrs = '0; tw_lo = 0;
        plan.delete();
        add_group(1, 0, 1'b0);
        foreach (plan[i]) begin
            step(plan[i]);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL twiddle[%0d] k=%0d got %b want %b", i, plan[i].k, obs(), expv());
            end
            if (plan[i].kind == KIND_SAMPLE && plan[i].k < 8 && tw_en) tw_lo++;
            if (plan[i].kind == KIND_SAMPLE && plan[i].k >= 8 && plan[i].k < 12 && tw_en)
                addrs = {addrs[11:0], tw_addr};
        end
        n_tests++;
        if (addrs !== 16'h0246 || tw_lo != 0) begin
            n_fail++;
            $display("FAIL twiddle_k8_11 got addrs=%h lo_en=%0d want addrs=0246 lo_en=0", addrs, tw_lo);
        end
    endtask

    task automatic test_back_to_back();
        int run, max_run, ov_idx;
        int offs[$];
        run = 0; max_run = 0; ov_idx = 0;
        plan.delete();
        add_idle(2, 1'b0);
        add_group(3, 0, 1'b0);
        add_idle(2, 1'b0);
        foreach (plan[i]) begin
            step(plan[i]);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL b2b[%0d] k=%0d got %b want %b", i, plan[i].k, obs(), expv());
            end
            if (out_sync) offs.push_back(ov_idx);
            if (out_valid) begin
                run++;
                ov_idx++;
            end else begin
                run = 0;
            end
            if (run > max_run) max_run = run;
        end
        n_tests++;
        if (max_run != 3 * N) begin
            n_fail++;
            $display("FAIL b2b_ov_run got %0d want %0d", max_run, 3 * N);
        end
        n_tests++;
        if (offs.size() != 3 || offs[0] != 0 || offs[1] != N || offs[2] != 2 * N) begin
            n_fail++;
            $display("FAIL b2b_sync_offsets got n=%0d %p want 0,%0d,%0d", offs.size(), offs, N, 2 * N);
        end
    endtask

    task automatic test_stall();
        int ov_cnt;
        ov_cnt = 0;
        plan.delete();
        for (int k = 0; k < 6; k++) plan.push_back(mk(KIND_SAMPLE, k, 1'b0, 1'b1, k == 0));
        for (int j = 0; j < 3; j++) plan.push_back(mk(KIND_STALL, 6, 1'b0, 1'b0, 1'b0));
        for (int k = 6; k < N; k++) plan.push_back(mk(KIND_SAMPLE, k, 1'b0, 1'b1, 1'b0));
        for (int k = N; k < N + D; k++) plan.push_back(mk(KIND_FLUSH, k, 1'b0, 1'b0, 1'b0));
        add_idle(2, 1'b0);
        foreach (plan[i]) begin
            step(plan[i]);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL stall[%0d] k=%0d got %b want %b", i, plan[i].k, obs(), expv());
            end
            if (out_valid) ov_cnt++;
        end
        n_tests++;
        if (ov_cnt != N) begin
            n_fail++;
            $display("FAIL stall_ov_count got %0d want %0d", ov_cnt, N);
        end
    endtask

    task automatic test_random();
        plan.delete();
        for (int g = 0; g < 8; g++) begin
            add_group(1 + $urandom_range(2), ERR_BUILD ? 0 : $urandom_range(25), !ERR_BUILD);
            add_idle(1 + $urandom_range(4), !ERR_BUILD);
        end
        foreach (plan[i]) begin
            step(plan[i]);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random[%0d] kind=%0d k=%0d got %b want %b",
                         i, plan[i].kind, plan[i].k, obs(), expv());
            end
        end
    endtask

    task automatic test_err();
        plan.delete();
        for (int k = 0; k < 6; k++) plan.push_back(mk(KIND_SAMPLE, k, 1'b0, 1'b1, k == 0));
        plan.push_back(mk(KIND_ERR, 6, 1'b0, 1'b0, 1'b0));
        add_idle(2, 1'b0);
        add_group(1, 0, 1'b0);
        add_idle(2, 1'b0);
        foreach (plan[i]) begin
            step(plan[i]);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL err[%0d] kind=%0d k=%0d got %b want %b",
                         i, plan[i].kind, plan[i].k, obs(), expv());
            end
        end
    endtask

    initial begin
        clr      = 1'b1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_twiddle();
        test_back_to_back();
        if (!ERR_BUILD) test_stall();
        test_random();
        if (ERR_BUILD) test_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdf_stage_ctrl.md
SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

Interface
REQ-001 SHALL have parameter N_POINTS, default 16; FFT frame length, a power of two from 4 to 1024.
REQ-002 SHALL have parameter STAGE, default 0; index of the radix-2 SDF stage, 0..log2(N_POINTS)-1.
REQ-003 SHALL derive local constants LOG2N = log2(N_POINTS) and DELAY = N_POINTS >> (STAGE+1), where DELAY is the depth of the stage's delay line.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 clr  in  1  reset, asynchronous and active-high.
REQ-006 in_valid  in  1  input sample present this cycle.
REQ-007 in_sync  in  1  current sample is frame index 0; only meaningful with in_valid.
REQ-008 bf_sel  out  1  0 = route the sample into the delay line (pass-through), 1 = butterfly.
REQ-009 tw_en  out  1  apply the twiddle to the delay-line output.
REQ-010 tw_addr  out  LOG2N  twiddle ROM address.
REQ-011 out_valid  out  1  stage output sample valid.
REQ-012 out_sync  out  1  first output sample of a frame.
REQ-013 busy  out  1  controller not in IDLE.
REQ-014 err  out  1  sticky protocol-error flag.

Function
REQ-015 SHALL implement four states, IDLE, FILL, RUN and FLUSH, and maintain a sample index k of width LOG2N+1.
REQ-016 IDLE: when in_valid&in_sync, set k=0 and go to FILL; otherwise hold.
REQ-017 FILL: k increments on each accepted sample; after sample k=DELAY-1, go to RUN.
REQ-018 RUN: after sample k=N_POINTS-1, if in_valid&in_sync arrives in the next cycle, restart k=0 and stay in RUN (back-to-back frames); otherwise go to FLUSH with k=N_POINTS.
REQ-019 FLUSH: k increments every cycle independent of in_valid; after k=N_POINTS+DELAY-1, go to IDLE.
REQ-020 All outputs SHALL be registered and, in the cycle after acceptance, describe sample k (datapath has a one-cycle input register).
REQ-021 bf_sel = bit (LOG2N-1-STAGE) of k, i.e. DELAY pass-through samples alternating with DELAY butterfly samples; bf_sel is forced to 0 in FLUSH.
REQ-022 tw_en = 1 when bf_sel=0 and k>=DELAY (RUN, FLUSH, or a back-to-back fill phase); otherwise 0.
REQ-023 tw_addr = (k mod DELAY) << STAGE, truncated to LOG2N bits; tw_addr = 0 when tw_en=0.
REQ-024 out_valid = 1 for k from DELAY to N_POINTS+DELAY-1 of each frame; in back-to-back operation out_valid stays continuously high.
REQ-025 out_sync = 1 for exactly one cycle, at the first out_valid of each frame.
REQ-026 busy = (state != IDLE).
REQ-027 Latency from input index 0 to out_sync SHALL be DELAY+1 cycles.

Reset
REQ-028 While clr=1: state = IDLE, k = 0, and all outputs = 0, including err.
REQ-029 clr asserted mid-frame SHALL abort the frame immediately; no out_valid is produced for that frame after release.

Configuration
REQ-030 Macro SDF_CTRL_ERR_EN defined: any of the following sets err=1 (sticky until clr) and moves the FSM to IDLE:
- in_valid=0 in FILL or RUN;
- in_valid&in_sync with k != 0 in FILL or RUN;
- in_valid=1 in FLUSH after its first cycle.
REQ-031 Macro SDF_CTRL_ERR_EN undefined: err is tied to 0; in_valid=0 in FILL/RUN freezes k and all outputs except out_valid and out_sync, which are 0 for that cycle; a mid-frame in_sync is ignored; in_valid in FLUSH is ignored.

Structure
REQ-032 Package fft_pkg SHALL hold the state enum type and a constant function clog2 shared by the FFT stages.
REQ-033 No sub-module; counter and FSM live in sdf_stage_ctrl.

Verification (N_POINTS=16, STAGE=1, DELAY=4)
REQ-034 Single frame: sync at k=0 plus 16 contiguous valids -> bf_sel per k is 0000111100001111; out_sync at k=4; out_valid for 16 cycles; FLUSH 4 cycles; busy drops at k=20.
REQ-035 Twiddle: same frame -> for k=8..11, tw_en=1 and tw_addr = 0,2,4,6; tw_en=0 for k=0..7.
REQ-036 Back-to-back frames: 3 frames without gaps -> out_valid high for 48 consecutive cycles, with out_sync at offsets 0, 16 and 32.
REQ-037 Reset: clr pulse at k=9 -> outputs 0 asynchronously; after release, no out_valid until a new sync.
REQ-038 With SDF_CTRL_ERR_EN: in_valid low at k=6 -> err=1 and busy=0 next cycle; a later sync starts a new frame while err stays 1.
REQ-039 Without SDF_CTRL_ERR_EN: in_valid low for 3 cycles at k=6 -> k holds; the frame completes with 16 valid outputs and err=0.
